appx_mult_arbiter: RTL and testbench
====================================

# appx_mult_arbiter

Shares one pipelined 16x16 approximate (power-of-two) multiplier among NREQ requesters. Round-robin arbitration, valid/ready handshakes on both sides, and a two-stage pipeline with full backpressure. Each result carries the ID of the requester that issued it. Sits between the datapath lanes and the shared approximate multiply resource in the functional-unit layer.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester ID (must equal clog2(NREQ))

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_a  in  16*NREQ  multiplicand, requester i at [16i+15:16i]
- req_b  in  16*NREQ  multiplier, same packing
- req_ready  out  NREQ  per-requester accept; at most one bit high
- res_valid  out  1  result valid
- res_y  out  32  approximate product
- res_id  out  IDW  requester index of this result
- res_ready  in  1  downstream accept

## Operation
- Approximation: y = a << k, where k = round-to-nearest power of two of b.
- b==0 gives y=0. b==1 gives k=0. b==2 gives k=1.
- For b≥3: p = MSB index of b; k = p + b[p-1]. Range is 2..16, e.g. b=3 gives k=2 and b=0xC000 gives k=16.
- The result is 32 bits, computed as zero-extended a shifted left; nothing is truncated.
- Pipeline:
  - S1 holds the granted a, b and id.
  - S2 holds y and id, and drives the res_* outputs directly from registers.
- Advance logic:
  - adv2 = !s2_valid || res_ready
  - adv1 = !s1_valid || adv2
- Arbitration:
  - Only when adv1 is high, grant the first requester with req_valid set, scanning from pointer rr to rr+NREQ-1 mod NREQ.
  - req_ready[g] = adv1 for the grant g; all other bits are 0.
  - req_ready is combinational from req_valid, rr, s1_valid, s2_valid and res_ready.
- On accept (req_valid[g] && req_ready[g]): S1 loads the operands, and rr becomes g+1 mod NREQ.
- Without an accept, rr holds.
- With no requests, nothing is granted and the bubble propagates.
- Stall: res_valid && !res_ready freezes S2. It also freezes S1 if S1 is valid. req_ready stays all-zero while S1 and S2 are both full and stalled.
- Once res_valid is high, res_y and res_id are stable until res_ready is sampled high.
- Reset:
  - res_valid=0, res_y=0, res_id=0.
  - s1_valid=0, rr=0, and req_ready=0 while rst_n is low.
  - Reset asserted mid-operation discards in-flight entries; no partial result is emitted afterwards.

## Timing
- Latency: accept at edge t puts the result on res_* after edge t+1, so it is valid in the cycle following t+1 (2 clocks).
- Throughput: 1 result per cycle with res_ready held high.
- Simultaneous events:
  - S2 draining and S1 loading in the same cycle is legal: S1 moves to S2 and the new request enters S1.
  - A requester deasserting valid while ungranted is legal.
  - Once req_valid is asserted, a requester holds it and its operands until accepted.
- Fairness: a continuously requesting requester is granted within NREQ accepts.

## Structure
- Shared package appx_mult_pkg:
  - OPW=16 and RESW=32 constants.
  - Function appx_shift(b) returning the 5-bit k.
- Sub-module appx_mult_core: purely combinational, inputs a and b, output y. It is instantiated between S1 and S2 and verified standalone against appx_shift.
- Round-robin pointer, grant logic and pipeline registers live in the top module.
- Expected size 150–250 lines of RTL.

## Test plan
- Core sweep, single requester 0, res_ready=1, a=0x1234:
  - b=0 → 0.
  - b=1 → 0x1234.
  - b=2 → 0x2468.
  - b=3 → 0x48D0.
  - b=5 → 0x48D0.
  - b=6 → 0x91A0.
  - b=0xC000 → 0x12340000.
  - b=0xFFFF → 0x12340000.
  - Each result has res_id=0 and appears 2 clocks after accept.
- All 4 requesters valid continuously, a=i+1, b=4, rr=0: accept order is 0,1,2,3,0… and the results stream back-to-back with res_y=4(i+1) and matching res_id.
- Backpressure: res_ready=0 for 5 cycles with requests pending.
  - At most 2 entries are accepted.
  - res_y and res_id are held stable.
  - req_ready=0 while full.
  - On release, there is no loss or duplication.
- Reset pulse of rst_n=0 with both stages full:
  - res_valid is 0 immediately (asynchronous).
  - After release, the first accept goes to requester 0, and no stale result appears.
- Sparse traffic: only requester 2 valid, then requester 1 the cycle after its accept: grants are 2 then 1, and rr ends at 2.

Source files
------------

// File: rtl/appx_mult_pkg.sv
// rtl/appx_mult_pkg.sv - shared widths and shift-amount helper for the approximate multiplier
package appx_mult_pkg;

  localparam int OPW  = 16;
  localparam int RESW = 32;
  localparam int KW   = 5;

  // Round b to the nearest power of two: MSB index plus the bit just below it.
  function automatic logic [KW-1:0] appx_shift(input logic [OPW-1:0] b);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 1; i < OPW; i++) begin
      if (b[i]) k = KW'(i) + KW'(b[i-1]);
    end
    return k;
  endfunction

endpackage

// File: rtl/appx_mult_core.sv
// rtl/appx_mult_core.sv - combinational power-of-two approximate 16x16 multiply
module appx_mult_core
  import appx_mult_pkg::*;
(
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic [RESW-1:0] y
);

  logic [KW-1:0] k;

  assign k = appx_shift(b);
  assign y = (b == '0) ? '0 : (RESW'(a) << k);

endmodule

// File: rtl/appx_mult_arbiter.sv
// rtl/appx_mult_arbiter.sv - round-robin share of one two-stage approximate multiplier
module appx_mult_arbiter
  import appx_mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [OPW*NREQ-1:0]  req_a,
  input  logic [OPW*NREQ-1:0]  req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  output logic [RESW-1:0]      res_y,
  output logic [IDW-1:0]       res_id,
  input  logic                 res_ready
);

  logic [IDW-1:0]  rr_q, rr_d;
  logic            s1_valid_q, s1_valid_d;
  logic [OPW-1:0]  s1_a_q, s1_a_d;
  logic [OPW-1:0]  s1_b_q, s1_b_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s2_valid_q, s2_valid_d;
  logic [RESW-1:0] s2_y_q, s2_y_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;

  logic            adv1, adv2;
  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand;
  logic [OPW-1:0]  gnt_a, gnt_b;
  logic            accept;
  logic [RESW-1:0] core_y;

  assign adv2 = !s2_valid_q || res_ready;
  assign adv1 = !s1_valid_q || adv2;

  // First valid requester at or after the pointer, wrapping at NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IDW'((int'(rr_q) + off) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        gnt_a = req_a[i*OPW +: OPW];
        gnt_b = req_b[i*OPW +: OPW];
      end
    end
  end

  assign accept    = rst_n && adv1 && grant_found;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

  appx_mult_core u_core (
    .a (s1_a_q),
    .b (s1_b_q),
    .y (core_y)
  );

  always_comb begin
    rr_d       = rr_q;
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    s2_id_d    = s2_id_q;

    if (adv1) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d  = gnt_a;
        s1_b_d  = gnt_b;
        s1_id_d = grant_idx;
        rr_d    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end

    // Result registers only change when a real entry moves in, keeping res_y quiet on bubbles.
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_y_d  = core_y;
        s2_id_d = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_id_q    <= '0;
    end else begin
      rr_q       <= rr_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign res_valid = s2_valid_q;
  assign res_y     = s2_y_q;
  assign res_id    = s2_id_q;

endmodule

// File: tb/tb_appx_mult_arbiter.sv
// tb/tb_appx_mult_arbiter.sv - directed self-checking bench for appx_mult_arbiter
module tb_appx_mult_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               res_valid;
  logic [31:0]        res_y;
  logic [IDW-1:0]     res_id;
  logic               res_ready;

  int errors = 0;
  int checks = 0;

  appx_mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_y     (res_y),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  logic [15:0] vb [8];
  logic [31:0] vy [8];
  logic [3:0]  rdy;
  int          acc;
  logic [33:0] got [$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vb = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0005, 16'h0006, 16'hC000, 16'hFFFF};
    vy = '{32'h0, 32'h1234, 32'h2468, 32'h48D0, 32'h48D0, 32'h91A0, 32'h12340000, 32'h12340000};

    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;

    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;

    // Core sweep through requester 0
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      set_req(0, 16'h1234, vb[i]);
      req_valid = 4'b0001;
      @(negedge clk);
      chk("core_rdy", req_ready, 4'b0001);
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      chk("core_lat1", res_valid, 0);
      @(negedge clk);
      chk("core_valid", res_valid, 1);
      chk("core_y", res_y, vy[i]);
      chk("core_id", res_id, 0);
    end

    // Round robin with all four requesters continuously valid
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(i + 1), 16'd4);
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 8) chk("rr_rdy", req_ready, 32'(1) << (c % 4));
      else       chk("rr_rdy_idle", req_ready, 0);
      if (c < 2) chk("rr_fill", res_valid, 0);
      else begin
        chk("rr_valid", res_valid, 1);
        chk("rr_id", res_id, (c - 2) % 4);
        chk("rr_y", res_y, 4 * ((c - 2) % 4 + 1));
      end
      @(posedge clk);
      #1;
      if (c == 7) req_valid = '0;
    end

    // Backpressure: res_ready low for five cycles with all requesters pending
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(16'h10 + i), 16'd2);
    req_valid = '1;
    res_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rdy = req_ready & req_valid;
      acc += $countones(rdy);
      if (res_valid && res_ready) got.push_back({res_id, res_y});
      if (c >= 2 && c <= 4) begin
        chk("stall_y", res_y, 32'h20);
        chk("stall_id", res_id, 0);
        chk("stall_rdy", req_ready, 0);
      end
      if (c == 4) chk("stall_acc", acc, 2);
      @(posedge clk);
      #1;
      req_valid = req_valid & ~rdy;
      res_ready = (c >= 4);
    end
    chk("bp_count", got.size(), 4);
    chk("bp_acc_total", acc, 4);
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      chk("bp_id", got[k][33:32], k);
      chk("bp_y", got[k][31:0], 2 * (32'h10 + k));
    end

    // Reset while both stages are full
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(16'h100 + i), 16'd1);
    req_valid = '1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("full_rdy0", req_ready, 4'b0001);
    @(negedge clk);
    chk("full_rdy1", req_ready, 4'b0010);
    @(negedge clk);
    chk("full_valid", res_valid, 1);
    chk("full_rdy", req_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", res_valid, 0);
    chk("rst_async_y", res_y, 0);
    chk("rst_async_rdy", req_ready, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", req_ready, 4'b0001);
    chk("post_rst_empty", res_valid, 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    chk("post_rst_nostale", res_valid, 0);
    @(negedge clk);
    chk("post_rst_valid", res_valid, 1);
    chk("post_rst_id", res_id, 0);
    chk("post_rst_y", res_y, 32'h100);

    // Sparse traffic: requester 2, then requester 1
    @(posedge clk);
    #1;
    set_req(2, 16'd7, 16'd1);
    set_req(1, 16'd9, 16'd2);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("sp_rdy2", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("sp_rdy1", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid = '1;
    @(negedge clk);
    chk("sp_rr_probe", req_ready, 4'b0100);
    chk("sp_res2_valid", res_valid, 1);
    chk("sp_res2_id", res_id, 2);
    chk("sp_res2_y", res_y, 32'd7);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    chk("sp_res1_valid", res_valid, 1);
    chk("sp_res1_id", res_id, 1);
    chk("sp_res1_y", res_y, 32'h12);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
